// File: rtl/anim_pkg.sv
// Shared types, pixel widths and the per-axis bounce rule for the box animator.
package anim_pkg;

   localparam int unsigned XW = 8;
   localparam int unsigned YW = 7;
   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {S_IDLE, S_ERASE, S_UPDATE, S_DRAW} state_e;

   typedef struct packed {
      logic          dir;
      logic [XW-1:0] pos;
   } axis_t;

   // dir 0 moves towards max_pos, dir 1 towards 0; both ends clamp and reverse.
   function automatic axis_t bounce(input logic [XW-1:0] pos, input logic dir,
                                    input int unsigned max_pos, input int unsigned step);
      axis_t       r;
      int unsigned p;
      p     = 32'(pos);
      r.dir = dir;
      r.pos = pos;
      if (!dir) begin
         if (p + step >= max_pos) begin
            r.pos = XW'(max_pos);
            r.dir = 1'b1;
         end else begin
            r.pos = XW'(p + step);
         end
      end else begin
         if (p <= step) begin
            r.pos = '0;
            r.dir = 1'b0;
         end else begin
            r.pos = XW'(p - step);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Frame pulse from a reloading down-counter, plus an update tick every Nth frame.
module frame_tick_gen #(
   parameter int unsigned CLOCKS_PER_FRAME  = 833333,
   parameter int unsigned FRAMES_PER_UPDATE = 15
) (
   input  logic clk_i,
   input  logic rst_i,
   output logic frame_o,
   output logic tick_o
);

   localparam int unsigned CntW = (CLOCKS_PER_FRAME > 1) ? $clog2(CLOCKS_PER_FRAME) : 1;
   localparam int unsigned FrmW = (FRAMES_PER_UPDATE > 1) ? $clog2(FRAMES_PER_UPDATE) : 1;

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [FrmW-1:0] fcnt_q, fcnt_d;
   logic            frame_q, frame_d;

   always_comb begin
      frame_d = (cnt_q == '0);
      cnt_d   = frame_d ? CntW'(CLOCKS_PER_FRAME - 1) : cnt_q - CntW'(1);
      tick_o  = frame_q && (fcnt_q == FrmW'(FRAMES_PER_UPDATE - 1));
      fcnt_d  = fcnt_q;
      if (frame_q) begin
         fcnt_d = tick_o ? '0 : fcnt_q + FrmW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q   <= CntW'(CLOCKS_PER_FRAME - 1);
         fcnt_q  <= '0;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         fcnt_q  <= fcnt_d;
         frame_q <= frame_d;
      end
   end

   assign frame_o = frame_q;

endmodule

// File: rtl/multi_box_animator.sv
// N independently bouncing boxes streamed as erase / move / redraw pixel phases
// over a valid/ready pixel interface.
module multi_box_animator
   import anim_pkg::*;
#(
   parameter int unsigned X_SCREEN_PIXELS   = 160,
   parameter int unsigned Y_SCREEN_PIXELS   = 120,
   parameter int unsigned X_BOXSIZE         = 4,
   parameter int unsigned Y_BOXSIZE         = 4,
   parameter int unsigned NUM_BOXES         = 2,
   parameter int unsigned STEP              = 1,
   parameter int unsigned CLOCKS_PER_FRAME  = 833333,
   parameter int unsigned FRAMES_PER_UPDATE = 15
) (
   input  logic                   iClock,
   input  logic                   iReset,
   input  logic                   iEnable,
   input  logic [3*NUM_BOXES-1:0] iColour,
   input  logic                   iPlotReady,
   output logic [XW-1:0]          oX,
   output logic [YW-1:0]          oY,
   output logic [CW-1:0]          oColour,
   output logic                   oPlot,
   output logic                   oBusy,
   output logic                   oFrame
);

   localparam int unsigned X_MAX = X_SCREEN_PIXELS - X_BOXSIZE;
   localparam int unsigned Y_MAX = Y_SCREEN_PIXELS - Y_BOXSIZE;
   localparam int unsigned BW    = (NUM_BOXES > 1) ? $clog2(NUM_BOXES) : 1;
   localparam int unsigned ColW  = (X_BOXSIZE > 1) ? $clog2(X_BOXSIZE) : 1;
   localparam int unsigned RowW  = (Y_BOXSIZE > 1) ? $clog2(Y_BOXSIZE) : 1;

   state_e                 state_q, state_d;
   logic [XW-1:0]          x_q [NUM_BOXES];
   logic [XW-1:0]          x_d [NUM_BOXES];
   logic [XW-1:0]          y_q [NUM_BOXES];
   logic [XW-1:0]          y_d [NUM_BOXES];
   logic [NUM_BOXES-1:0]   dirx_q, dirx_d, diry_q, diry_d;
   axis_t                  nx [NUM_BOXES];
   axis_t                  ny [NUM_BOXES];
   logic [BW-1:0]          box_q, box_d;
   logic [ColW-1:0]        col_q, col_d;
   logic [RowW-1:0]        row_q, row_d;
   logic                   loaded_q, loaded_d;
   logic [XW-1:0]          ox_q, ox_d;
   logic [YW-1:0]          oy_q, oy_d;
   logic [CW-1:0]          oc_q, oc_d;
   logic                   plot_q, plot_d;
   logic                   busy_q, busy_d;
   logic                   req_q, req_d;
   logic                   tick;
   logic                   accept, last_pix;

   frame_tick_gen #(
      .CLOCKS_PER_FRAME (CLOCKS_PER_FRAME),
      .FRAMES_PER_UPDATE(FRAMES_PER_UPDATE)
   ) u_frame_tick_gen (
      .clk_i  (iClock),
      .rst_i  (iReset),
      .frame_o(oFrame),
      .tick_o (tick)
   );

   always_comb begin
      for (int i = 0; i < NUM_BOXES; i++) begin
         nx[i] = bounce(x_q[i], dirx_q[i], X_MAX, STEP);
         ny[i] = bounce(y_q[i], diry_q[i], Y_MAX, STEP);
      end
   end

   assign accept   = plot_q && iPlotReady;
   assign last_pix = (box_q == BW'(NUM_BOXES - 1)) && (col_q == ColW'(X_BOXSIZE - 1)) &&
                     (row_q == RowW'(Y_BOXSIZE - 1));

   always_comb begin
      state_d  = state_q;
      x_d      = x_q;
      y_d      = y_q;
      dirx_d   = dirx_q;
      diry_d   = diry_q;
      box_d    = box_q;
      col_d    = col_q;
      row_d    = row_q;
      loaded_d = loaded_q;
      ox_d     = ox_q;
      oy_d     = oy_q;
      oc_d     = oc_q;
      plot_d   = plot_q;
      unique case (state_q)
         S_IDLE: begin
            if (req_q) state_d = S_ERASE;
         end
         S_UPDATE: begin
            for (int i = 0; i < NUM_BOXES; i++) begin
               x_d[i]    = nx[i].pos;
               dirx_d[i] = nx[i].dir;
               y_d[i]    = ny[i].pos;
               diry_d[i] = ny[i].dir;
            end
            state_d = S_DRAW;
         end
         S_ERASE, S_DRAW: begin
            if (accept) plot_d = 1'b0;
            if (accept && loaded_q) begin
               state_d  = (state_q == S_ERASE) ? S_UPDATE : S_IDLE;
               box_d    = '0;
               col_d    = '0;
               row_d    = '0;
               loaded_d = 1'b0;
            end else if (!loaded_q && (!plot_q || iPlotReady)) begin
               // Load the next pixel into the output register; counters point one ahead.
               ox_d     = x_q[box_q] + XW'(col_q);
               oy_d     = YW'(y_q[box_q] + XW'(row_q));
               oc_d     = (state_q == S_DRAW) ? iColour[CW*box_q +: CW] : '0;
               plot_d   = 1'b1;
               loaded_d = last_pix;
               if (col_q == ColW'(X_BOXSIZE - 1)) begin
                  col_d = '0;
                  if (row_q == RowW'(Y_BOXSIZE - 1)) begin
                     row_d = '0;
                     box_d = box_q + BW'(1);
                  end else begin
                     row_d = row_q + RowW'(1);
                  end
               end else begin
                  col_d = col_q + ColW'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
      // A tick while a request is pending, or on the cycle it is consumed, is dropped.
      if (!iEnable) begin
         req_d = 1'b0;
      end else if (state_q == S_IDLE && req_q) begin
         req_d = 1'b0;
      end else if (tick) begin
         req_d = 1'b1;
      end else begin
         req_d = req_q;
      end
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state_q  <= S_DRAW;
         for (int i = 0; i < NUM_BOXES; i++) begin
            x_q[i] <= XW'((2 * i * X_BOXSIZE) % (X_MAX + 1));
            y_q[i] <= XW'((i * Y_BOXSIZE) % (Y_MAX + 1));
         end
         dirx_q   <= '0;
         diry_q   <= '0;
         box_q    <= '0;
         col_q    <= '0;
         row_q    <= '0;
         loaded_q <= 1'b0;
         ox_q     <= '0;
         oy_q     <= '0;
         oc_q     <= '0;
         plot_q   <= 1'b0;
         busy_q   <= 1'b0;
         req_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         x_q      <= x_d;
         y_q      <= y_d;
         dirx_q   <= dirx_d;
         diry_q   <= diry_d;
         box_q    <= box_d;
         col_q    <= col_d;
         row_q    <= row_d;
         loaded_q <= loaded_d;
         ox_q     <= ox_d;
         oy_q     <= oy_d;
         oc_q     <= oc_d;
         plot_q   <= plot_d;
         busy_q   <= busy_d;
         req_q    <= req_d;
      end
   end

   assign oX      = ox_q;
   assign oY      = oy_q;
   assign oColour = oc_q;
   assign oPlot   = plot_q;
   assign oBusy   = busy_q;

endmodule
